json_command_parser: RTL

JSON_COMMAND_PARSER -- requirements
Module: json_command_parser

---
 rtl/json_cmd_pkg.sv | 56 +++++
 rtl/ascii_digit_decoder.sv | 19 +
 rtl/json_command_parser.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/json_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : json_cmd_pkg
// Description : Shared constants, field positions, FSM state type and the
//               speed arithmetic helper for the JSON command frame.
//               Shared by the parser and the encoder-side command translator.
// Revision    : 1.0 - initial release
// ============================================================================
package json_cmd_pkg;

    // Character literals used by the frame
    localparam logic [7:0] LBRACE = 8'h7b;
    localparam logic [7:0] QUOTE  = 8'h22;
    localparam logic [7:0] COLON  = 8'h3a;
    localparam logic [7:0] COMMA  = 8'h2c;
    localparam logic [7:0] DOT    = 8'h2e;
    localparam logic [7:0] MINUS  = 8'h2d;
    localparam logic [7:0] ZERO   = 8'h30;
    localparam logic [7:0] ONE    = 8'h31;
    localparam logic [7:0] RBRACE = 8'h7d;
    localparam logic [7:0] LF     = 8'h0a;
    localparam logic [7:0] CHAR_T = 8'h54;
    localparam logic [7:0] CHAR_L = 8'h4c;
    localparam logic [7:0] CHAR_R = 8'h52;

    // Frame geometry
    localparam int         FRAME_LEN = 28;
    localparam logic [4:0] T_POS     = 5'd5;
    localparam logic [4:0] L_SIGN    = 5'd11;
    localparam logic [4:0] L_D1      = 5'd14;
    localparam logic [4:0] L_D2      = 5'd15;
    localparam logic [4:0] R_SIGN    = 5'd21;
    localparam logic [4:0] R_D1      = 5'd24;
    localparam logic [4:0] R_D2      = 5'd25;
    localparam logic [4:0] LAST_POS  = 5'(FRAME_LEN - 1);

    // Parser FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed speed in hundredths from sign flag and two BCD digits.
    // 10*tens is built as 8*tens + 2*tens in 7 bits (max 99 fits).
    function automatic logic [7:0] speed_from_digits(input logic       neg,
                                                     input logic [3:0] tens,
                                                     input logic [3:0] ones);
        logic [6:0] mag;
        mag = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
        // Negating zero yields zero, so "-0.00" decodes to 0 naturally
        return neg ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    endfunction

endpackage : json_cmd_pkg
`default_nettype wire

// File: rtl/ascii_digit_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ascii_digit_decoder
// Description : Classifies an ASCII byte as a decimal digit and returns its
//               binary value.
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_digit_decoder (
    input  logic [7:0] data,
    output logic       is_digit,
    output logic [3:0] value
);

    // '0'..'9' occupy 0x30..0x39, so the low nibble is the value
    assign is_digit = (data >= 8'h30) && (data <= 8'h39);
    assign value    = data[3:0];

endmodule : ascii_digit_decoder
`default_nettype wire

// File: rtl/json_command_parser.sv
`default_nettype none
// ============================================================================
// Module      : json_command_parser
// Description : Streaming parser for the fixed 28-byte JSON drive command
//               {"T":t,"L":s0.dd,"R":s0.dd}\n. Outputs update atomically one
//               cycle after the terminating line feed.
// Revision    : 1.0 - initial release
// ============================================================================
module json_command_parser
    import json_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              trigger,
    output logic signed [7:0] left_speed,
    output logic signed [7:0] right_speed,
    output logic              frame_valid,
    output logic              frame_error
);

    state_t     r_state;
    logic [4:0] r_pos;

    // Shadow copies of the field bytes of the frame in progress
    logic       r_t_sh;
    logic       r_l_neg;
    logic [3:0] r_l_tens;
    logic [3:0] r_l_ones;
    logic       r_r_neg;
    logic [3:0] r_r_tens;
    logic [3:0] r_r_ones;

    logic       w_is_digit;
    logic [3:0] w_digit;
    logic       w_match;
    logic [7:0] w_left;
    logic [7:0] w_right;

    // Single shared digit decoder serving all four digit positions
    ascii_digit_decoder u_digit (
        .data     (rx_data),
        .is_digit (w_is_digit),
        .value    (w_digit)
    );

    assign w_left  = speed_from_digits(r_l_neg, r_l_tens, r_l_ones);
    assign w_right = speed_from_digits(r_r_neg, r_r_tens, r_r_ones);

    // Check the incoming byte against the literal or class expected at r_pos
    always_comb begin
        w_match = 1'b0;
        case (r_pos)
            5'd1, 5'd3, 5'd7, 5'd9, 5'd17, 5'd19: w_match = (rx_data == QUOTE);
            5'd2:                                 w_match = (rx_data == CHAR_T);
            5'd4, 5'd10, 5'd20:                   w_match = (rx_data == COLON);
            T_POS:                                w_match = (rx_data == ZERO) || (rx_data == ONE);
            5'd6, 5'd16:                          w_match = (rx_data == COMMA);
            5'd8:                                 w_match = (rx_data == CHAR_L);
            5'd18:                                w_match = (rx_data == CHAR_R);
            L_SIGN, R_SIGN:                       w_match = (rx_data == MINUS) || (rx_data == ZERO);
            5'd12, 5'd22:                         w_match = (rx_data == ZERO);
            5'd13, 5'd23:                         w_match = (rx_data == DOT);
            L_D1, L_D2, R_D1, R_D2:               w_match = w_is_digit;
            5'd26:                                w_match = (rx_data == RBRACE);
            LAST_POS:                             w_match = (rx_data == LF);
            default:                              w_match = 1'b0;
        endcase
    end

    // Frame FSM, shadow capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pos       <= 5'd0;
            r_t_sh      <= 1'b0;
            r_l_neg     <= 1'b0;
            r_l_tens    <= 4'd0;
            r_l_ones    <= 4'd0;
            r_r_neg     <= 1'b0;
            r_r_tens    <= 4'd0;
            r_r_ones    <= 4'd0;
            trigger     <= 1'b0;
            left_speed  <= 8'sd0;
            right_speed <= 8'sd0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (r_state)
                // DONE behaves like IDLE so a '{' right after '\n' is not lost
                ST_IDLE, ST_DONE: begin
                    if (rx_valid && (rx_data == LBRACE)) begin
                        r_state <= ST_BODY;
                        r_pos   <= 5'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_pos   <= 5'd0;
                    end
                end
                ST_BODY: begin
                    if (rx_valid) begin
                        if (w_match) begin
                            case (r_pos)
                                T_POS:   r_t_sh   <= rx_data[0];
                                L_SIGN:  r_l_neg  <= (rx_data == MINUS);
                                L_D1:    r_l_tens <= w_digit;
                                L_D2:    r_l_ones <= w_digit;
                                R_SIGN:  r_r_neg  <= (rx_data == MINUS);
                                R_D1:    r_r_tens <= w_digit;
                                R_D2:    r_r_ones <= w_digit;
                                default: ;
                            endcase
                            if (r_pos == LAST_POS) begin
                                trigger     <= r_t_sh;
                                left_speed  <= w_left;
                                right_speed <= w_right;
                                frame_valid <= 1'b1;
                                r_state     <= ST_DONE;
                                r_pos       <= 5'd0;
                            end else begin
                                r_pos <= r_pos + 5'd1;
                            end
                        end else begin
                            // Abort; a stray '{' starts a fresh frame at once
                            frame_error <= 1'b1;
                            if (rx_data == LBRACE) begin
                                r_state <= ST_BODY;
                                r_pos   <= 5'd1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_pos   <= 5'd0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pos   <= 5'd0;
                end
            endcase
        end
    end

endmodule : json_command_parser
`default_nettype wire
